// File: rtl/norflash_linebuf_pkg.sv
// norflash_linebuf_pkg
// Shared definitions for the NOR-flash single-line read buffer:
//   - state_e    : FSM state encoding (IDLE, FILL, RESP, HOLD)
//   - LINE_WORDS : number of 32-bit words in the buffered line
//   - WORD_IDX_W : width of a word index within the line
//   - SEL_ALL    : byte-select value used for every master access
//   - WORD_BYTES : master address step between consecutive words
package norflash_linebuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam int          LINE_WORDS = 4;
    localparam int          WORD_IDX_W = 2;
    localparam logic [3:0]  SEL_ALL    = 4'b1111;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/norflash_linebuf_store.sv
// norflash_linebuf_store
// Tag, valid bit and data words of the single buffered line.
// Ports:
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   word_we/idx/dat       : write one data word of the line
//   tag_we/tag_dat        : write the line tag
//   valid_we/valid_dat    : write the valid bit (set or clear)
//   rd_idx / rd_dat       : combinational read of one data word
//   tag_o, valid_o        : current tag and valid bit
module norflash_linebuf_store
    import norflash_linebuf_pkg::*;
#(
    parameter int TAG_W = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  word_we,
    input  logic [WORD_IDX_W-1:0] word_idx,
    input  logic [31:0]           word_dat,
    input  logic                  tag_we,
    input  logic [TAG_W-1:0]      tag_dat,
    input  logic                  valid_we,
    input  logic                  valid_dat,
    input  logic [WORD_IDX_W-1:0] rd_idx,
    output logic [31:0]           rd_dat,
    output logic [TAG_W-1:0]      tag_o,
    output logic                  valid_o
);

    logic [LINE_WORDS-1:0][31:0] words_q, words_d;
    logic [TAG_W-1:0]            tag_q, tag_d;
    logic                        valid_q, valid_d;

    always_comb begin
        words_d = words_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        if (word_we) begin
            words_d[word_idx] = word_dat;
        end
        if (tag_we) begin
            tag_d = tag_dat;
        end
        if (valid_we) begin
            valid_d = valid_dat;
        end
    end

    // Clearing the words on reset discards any partially filled line.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_q <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            words_q <= words_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    assign rd_dat  = words_q[rd_idx];
    assign tag_o   = tag_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/norflash_linebuf.sv
// norflash_linebuf
// One-line (16-byte) read buffer between a Wishbone slave port and a
// norflash16 master port. Reads that hit the line are answered in one cycle;
// misses fetch the whole line (4 words, ascending from the line base) first.
// Writes are acknowledged without touching flash and drop the line.
// Optional feature macro: NORFLASH_LINEBUF_STATS_EN enables the hit counter;
// without it hit_count_o is tied to zero and no counter register exists.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   wb_*             : Wishbone slave (CPU side)
//   m_*              : master towards norflash16
//   inv_i            : one-cycle pulse, invalidates the line
//   hit_count_o      : number of hit acks (stats build only)
//   dbg_state_o      : current FSM state, for observation
//
// Handshakes: a slave request is cyc&stb, sampled only in IDLE; the answer is
// a single-cycle wb_ack_o followed by a mandatory idle cycle (HOLD), so the
// requester must drop stb after seeing ack. On the master side m_stb_o stays
// high until m_ack_i is sampled, then drops for exactly one cycle before the
// next word is requested; m_cyc_o spans the whole four-word fill.
module norflash_linebuf
    import norflash_linebuf_pkg::*;
#(
    parameter int adr_width = 23
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] wb_adr_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic [31:0] m_adr_o,
    input  logic [31:0] m_dat_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic [3:0]  m_sel_o,
    input  logic        m_ack_i,
    input  logic        inv_i,
    output logic [31:0] hit_count_o,
    output logic [1:0]  dbg_state_o
);

    localparam int TAG_W = adr_width - 4;

    state_e                state_q, state_d;
    logic [WORD_IDX_W-1:0] cnt_q, cnt_d;
    logic [WORD_IDX_W-1:0] req_word_q, req_word_d;
    logic [TAG_W-1:0]      req_tag_q, req_tag_d;
    logic                  inv_seen_q, inv_seen_d;
    logic                  abort_q, abort_d;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;
    logic                  m_cyc_q, m_cyc_d;
    logic                  m_stb_q, m_stb_d;
    logic [31:0]           m_adr_q, m_adr_d;

    logic                  st_word_we;
    logic                  st_tag_we;
    logic                  st_valid_we;
    logic                  st_valid_dat;
    logic [31:0]           st_rd_dat;
    logic [TAG_W-1:0]      st_tag;
    logic                  st_valid;

    logic                  rd_req;
    logic                  wr_req;
    logic                  line_hit;

    assign rd_req = wb_cyc_i & wb_stb_i & ~wb_we_i;
    assign wr_req = wb_cyc_i & wb_stb_i & wb_we_i;
    // An invalidate arriving together with a request wins: the request misses.
    assign line_hit = st_valid && (st_tag == wb_adr_i[adr_width-1:4]) && !inv_i;

    // Byte selects are ignored and address bits outside the window or below
    // word granularity carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{wb_sel_i, wb_adr_i[31:adr_width], wb_adr_i[1:0]};

    norflash_linebuf_store #(
        .TAG_W (TAG_W)
    ) u_store (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .word_we   (st_word_we),
        .word_idx  (cnt_q),
        .word_dat  (m_dat_i),
        .tag_we    (st_tag_we),
        .tag_dat   (req_tag_q),
        .valid_we  (st_valid_we),
        .valid_dat (st_valid_dat),
        .rd_idx    (wb_adr_i[3:2]),
        .rd_dat    (st_rd_dat),
        .tag_o     (st_tag),
        .valid_o   (st_valid)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_word_d   = req_word_q;
        req_tag_d    = req_tag_q;
        inv_seen_d   = inv_seen_q;
        abort_d      = abort_q;
        ack_d        = 1'b0;
        dat_d        = dat_q;
        m_cyc_d      = m_cyc_q;
        m_stb_d      = m_stb_q;
        m_adr_d      = m_adr_q;
        st_word_we   = 1'b0;
        st_tag_we    = 1'b0;
        st_valid_we  = 1'b0;
        st_valid_dat = 1'b0;

        // An invalidate pulse clears the line in any state; a fill in
        // progress additionally remembers it so it does not revalidate.
        if (inv_i) begin
            st_valid_we  = 1'b1;
            st_valid_dat = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    st_valid_we  = 1'b1;
                    st_valid_dat = 1'b0;
                    ack_d        = 1'b1;
                    state_d      = ST_RESP;
                end else if (rd_req) begin
                    if (line_hit) begin
                        dat_d   = st_rd_dat;
                        ack_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        // The words are about to be overwritten, so the old
                        // line must stop matching right away.
                        st_valid_we  = 1'b1;
                        st_valid_dat = 1'b0;
                        cnt_d        = '0;
                        req_word_d   = wb_adr_i[3:2];
                        req_tag_d    = wb_adr_i[adr_width-1:4];
                        inv_seen_d   = 1'b0;
                        abort_d      = 1'b0;
                        m_cyc_d      = 1'b1;
                        m_stb_d      = 1'b1;
                        m_adr_d      = {{(32-adr_width){1'b0}}, wb_adr_i[adr_width-1:4], 4'b0000};
                        state_d      = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                if (inv_i) begin
                    inv_seen_d = 1'b1;
                end
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (m_stb_q && m_ack_i) begin
                    st_word_we = 1'b1;
                    cnt_d      = cnt_q + 2'd1;
                    m_adr_d    = m_adr_q + WORD_BYTES;
                    m_stb_d    = 1'b0;
                    if (cnt_q == req_word_q) begin
                        dat_d = m_dat_i;
                    end
                    if (cnt_q == 2'd3) begin
                        m_cyc_d   = 1'b0;
                        st_tag_we = 1'b1;
                        if (!inv_seen_q && !inv_i) begin
                            st_valid_we  = 1'b1;
                            st_valid_dat = 1'b1;
                        end
                        // A requester that walked away gets no ack.
                        ack_d   = wb_cyc_i && !abort_q;
                        state_d = ST_RESP;
                    end
                end else if (!m_stb_q) begin
                    m_stb_d = 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_word_q <= '0;
            req_tag_q  <= '0;
            inv_seen_q <= 1'b0;
            abort_q    <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            m_cyc_q    <= 1'b0;
            m_stb_q    <= 1'b0;
            m_adr_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_word_q <= req_word_d;
            req_tag_q  <= req_tag_d;
            inv_seen_q <= inv_seen_d;
            abort_q    <= abort_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            m_cyc_q    <= m_cyc_d;
            m_stb_q    <= m_stb_d;
            m_adr_q    <= m_adr_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign m_cyc_o     = m_cyc_q;
    assign m_stb_o     = m_stb_q;
    assign m_adr_o     = m_adr_q;
    assign m_sel_o     = SEL_ALL;
    assign dbg_state_o = state_q;

`ifdef NORFLASH_LINEBUF_STATS_EN
    // Counts at the edge that launches a hit ack; wraps naturally at 2^32.
    logic        hit_ev;
    logic [31:0] hit_cnt_q, hit_cnt_d;

    assign hit_ev = (state_q == ST_IDLE) && rd_req && !wr_req && line_hit;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (hit_ev) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_count_o = hit_cnt_q;
`else
    assign hit_count_o = '0;
`endif

endmodule

// File: tb/tb_norflash_linebuf.sv
`timescale 1ns/1ps
module tb_norflash_linebuf;

    localparam int ADR_W = 23;

    // ---------------- clock / reset ----------------
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [3:0]  wb_sel_i = 4'hf;
    logic        wb_ack_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_i = '0;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic [3:0]  m_sel_o;
    logic        m_ack_i = 1'b0;
    logic        inv_i   = 1'b0;
    logic [31:0] hit_count_o;
    logic [1:0]  dbg_state_o;

    norflash_linebuf #(.adr_width(ADR_W)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_o    (wb_dat_o),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_sel_i    (wb_sel_i),
        .wb_ack_o    (wb_ack_o),
        .m_adr_o     (m_adr_o),
        .m_dat_i     (m_dat_i),
        .m_cyc_o     (m_cyc_o),
        .m_stb_o     (m_stb_o),
        .m_sel_o     (m_sel_o),
        .m_ack_i     (m_ack_i),
        .inv_i       (inv_i),
        .hit_count_o (hit_count_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_acks   = 0;
    int          exp_hits = 0;
    logic [31:0] exp_q[$];
    logic [31:0] madr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_hc();
`ifdef NORFLASH_LINEBUF_STATS_EN
        return 32'(exp_hits);
`else
        return 32'd0;
`endif
    endfunction

    task automatic push_fill(input logic [31:0] adr);
        for (int k = 0; k < 4; k++) madr_q.push_back((adr & 32'h007ffff0) + 32'(4 * k));
    endtask

    // ---------------- flash model: data = address + 1 ----------------
    int unsigned fl_wait = 0;
    always @(negedge sys_clk) begin
        if (m_ack_i) begin
            m_ack_i = 1'b0;
            if (m_cyc_o) check("m_stb_gap", 32'(m_stb_o), 32'd0);
        end else if (m_cyc_o && m_stb_o) begin
            if (fl_wait == 0) begin
                m_ack_i = 1'b1;
                m_dat_i = m_adr_o + 32'd1;
                m_acks++;
                check("m_sel", 32'(m_sel_o), 32'hf);
                if (madr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL m_adr_unexpected: got 0x%08h, want no access", m_adr_o);
                end else begin
                    check("m_adr", m_adr_o, madr_q.pop_front());
                end
                fl_wait = $urandom_range(0, 2);
            end else begin
                fl_wait--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp,
                           input bit pulse_inv, output int lat);
        int m0;
        bit done;
        bit inv_done;
        exp_q.push_back(exp);
        @(negedge sys_clk);
        wb_adr_i = adr; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        wb_sel_i = 4'($urandom_range(0, 15));
        m0 = m_acks; lat = 0; done = 0; inv_done = 0;
        while (!done && lat < 200) begin
            @(negedge sys_clk);
            lat++;
            inv_i = 1'b0;
            if (wb_ack_o) done = 1;
            else if (pulse_inv && !inv_done && m_acks > m0) begin
                inv_i = 1'b1;
                inv_done = 1;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL rd_timeout: no ack for 0x%08h, want ack", adr);
            void'(exp_q.pop_back());
        end else begin
            check($sformatf("rd_data@%08h", adr), wb_dat_o, exp_q.pop_front());
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; inv_i = 1'b0;
        @(negedge sys_clk);
        check("ack_single", 32'(wb_ack_o), 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] adr, output int lat);
        bit done;
        @(negedge sys_clk);
        wb_adr_i = adr; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        lat = 0; done = 0;
        while (!done && lat < 200) begin
            @(negedge sys_clk);
            lat++;
            if (wb_ack_o) done = 1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge sys_clk);
        check("ack_single_wr", 32'(wb_ack_o), 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic        inv;
        logic [31:0] dat;
        int          macc;
        logic        hit;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int lat;
        int m0;
        int cyc;
        int acks_seen;

        vecs[0]  = '{32'h0000fff4, 1'b0, 1'b0, 32'h0000fff5, 4, 1'b0};
        vecs[1]  = '{32'h0000fff8, 1'b0, 1'b0, 32'h0000fff9, 0, 1'b1};
        vecs[2]  = '{32'h0000fffc, 1'b0, 1'b0, 32'h0000fffd, 0, 1'b1};
        vecs[3]  = '{32'h00000010, 1'b0, 1'b0, 32'h00000011, 4, 1'b0};
        vecs[4]  = '{32'h0000001c, 1'b0, 1'b0, 32'h0000001d, 0, 1'b1};
        vecs[5]  = '{32'h00000014, 1'b0, 1'b1, 32'h00000015, 4, 1'b0};
        vecs[6]  = '{32'h00000018, 1'b0, 1'b0, 32'h00000019, 0, 1'b1};
        vecs[7]  = '{32'h00000018, 1'b1, 1'b0, 32'h00000000, 0, 1'b0};
        vecs[8]  = '{32'h00000018, 1'b0, 1'b0, 32'h00000019, 4, 1'b0};
        vecs[9]  = '{32'h00800018, 1'b0, 1'b0, 32'h00000019, 0, 1'b1};
        vecs[10] = '{32'h007ffff8, 1'b0, 1'b0, 32'h007ffff9, 4, 1'b0};
        vecs[11] = '{32'h007ffff0, 1'b0, 1'b0, 32'h007ffff1, 0, 1'b1};

        // reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_ack",   32'(wb_ack_o),    32'd0);
        check("rst_dat",   wb_dat_o,         32'd0);
        check("rst_mcyc",  32'(m_cyc_o),     32'd0);
        check("rst_mstb",  32'(m_stb_o),     32'd0);
        check("rst_madr",  m_adr_o,          32'd0);
        check("rst_msel",  32'(m_sel_o),     32'hf);
        check("rst_hits",  hit_count_o,      32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // table-driven main function
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].inv) begin
                @(negedge sys_clk);
                inv_i = 1'b1;
                @(negedge sys_clk);
                inv_i = 1'b0;
            end
            if (vecs[i].macc != 0) push_fill(vecs[i].adr);
            m0 = m_acks;
            if (vecs[i].we) begin
                wb_write(vecs[i].adr, lat);
                check($sformatf("v%0d_wr_lat", i), 32'(lat), 32'd1);
            end else begin
                wb_read(vecs[i].adr, vecs[i].dat, 1'b0, lat);
                if (vecs[i].hit) begin
                    exp_hits++;
                    check($sformatf("v%0d_hit_lat", i), 32'(lat), 32'd1);
                end else begin
                    check($sformatf("v%0d_miss_lat", i), 32'(lat >= 5), 32'd1);
                end
            end
            check($sformatf("v%0d_macc", i), 32'(m_acks - m0), 32'(vecs[i].macc));
            check($sformatf("v%0d_hits", i), hit_count_o, exp_hc());
        end

        // invalidate during a fill: data delivered, line left invalid
        push_fill(32'h20);
        m0 = m_acks;
        wb_read(32'h20, 32'h21, 1'b1, lat);
        check("invfill_macc", 32'(m_acks - m0), 32'd4);
        push_fill(32'h24);
        m0 = m_acks;
        wb_read(32'h24, 32'h25, 1'b0, lat);
        check("invfill_refill", 32'(m_acks - m0), 32'd4);

        // requester drops cyc mid-fill: fill completes, no ack, line valid
        push_fill(32'h30);
        m0 = m_acks;
        acks_seen = 0;
        @(negedge sys_clk);
        wb_adr_i = 32'h30; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        cyc = 0;
        while (m_acks == m0 && cyc < 200) begin
            @(negedge sys_clk); cyc++;
            if (wb_ack_o) acks_seen++;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        cyc = 0;
        while (m_cyc_o && cyc < 200) begin
            @(negedge sys_clk); cyc++;
            if (wb_ack_o) acks_seen++;
        end
        check("abort_fill_done", 32'(m_cyc_o), 32'd0);
        repeat (4) begin
            @(negedge sys_clk);
            if (wb_ack_o) acks_seen++;
        end
        check("abort_no_ack", 32'(acks_seen), 32'd0);
        check("abort_macc", 32'(m_acks - m0), 32'd4);
        m0 = m_acks;
        wb_read(32'h34, 32'h35, 1'b0, lat);
        exp_hits++;
        check("abort_hit_lat", 32'(lat), 32'd1);
        check("abort_hit_macc", 32'(m_acks - m0), 32'd0);
        check("abort_hits", hit_count_o, exp_hc());

        // reset mid-fill: master drops next cycle, next read misses
        push_fill(32'h40);
        m0 = m_acks;
        @(negedge sys_clk);
        wb_adr_i = 32'h40; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        cyc = 0;
        while (m_acks == m0 && cyc < 200) begin
            @(negedge sys_clk); cyc++;
        end
        check("rstfill_started", 32'(m_cyc_o), 32'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("rstfill_mcyc",  32'(m_cyc_o),     32'd0);
        check("rstfill_mstb",  32'(m_stb_o),     32'd0);
        check("rstfill_state", 32'(dbg_state_o), 32'd0);
        check("rstfill_dat",   wb_dat_o,         32'd0);
        check("rstfill_hits",  hit_count_o,      32'd0);
        sys_rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        madr_q.delete();
        exp_hits = 0;
        repeat (2) @(negedge sys_clk);
        push_fill(32'h44);
        m0 = m_acks;
        wb_read(32'h44, 32'h45, 1'b0, lat);
        check("rstfill_miss_macc", 32'(m_acks - m0), 32'd4);
        m0 = m_acks;
        wb_read(32'h48, 32'h49, 1'b0, lat);
        exp_hits++;
        check("rstfill_hit_lat", 32'(lat), 32'd1);
        check("rstfill_hit_macc", 32'(m_acks - m0), 32'd0);
        check("rstfill_hits2", hit_count_o, exp_hc());

        // final report
        repeat (4) @(negedge sys_clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("madr_q_empty", 32'(madr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/norflash_linebuf.md
NORFLASH_LINEBUF -- requirements
Module: norflash_linebuf

Interface
REQ-001 SHALL have parameter adr_width, default 23, byte-address width of the flash window.
REQ-002 SHALL have port sys_clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port sys_rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have slave ports: wb_adr_i in 32, wb_dat_o out 32, wb_cyc_i in 1, wb_stb_i in 1, wb_we_i in 1, wb_sel_i in 4, wb_ack_o out 1.
REQ-005 SHALL have master ports to norflash16: m_adr_o out 32, m_dat_i in 32, m_cyc_o out 1, m_stb_o out 1, m_sel_o out 4, m_ack_i in 1.
REQ-006 SHALL have port inv_i, input, 1, one-cycle pulse that invalidates the line.
REQ-007 SHALL have port hit_count_o, output, 32, count of reads served from the line.

Function
REQ-008 SHALL hold one 16-byte line: four 32-bit words, tag = address bits [adr_width-1:4], and a valid bit.
REQ-009 SHALL use FSM states IDLE, FILL, RESP, HOLD.
REQ-010 IDLE, read request (cyc&stb&~we) with valid and tag match: SHALL drive wb_dat_o from word adr[3:2] and go to RESP.
REQ-011 IDLE, read miss: SHALL go to FILL, with word counter 0 and m_adr_o = {line base, 4'b0}.
REQ-012 FILL: SHALL hold m_cyc_o = m_stb_o = 1 and m_sel_o = 4'b1111 until m_ack_i.
  - On each m_ack_i: store m_dat_i into word[counter], increment counter, and advance m_adr_o by 4.
  - Deassert m_stb_o for one cycle between words.
REQ-013 After the 4th m_ack_i: SHALL write the tag, set valid, and go to RESP.
  - Exception: valid stays 0 if inv_i arrived during FILL; the data still goes to the CPU.
REQ-014 RESP: SHALL assert wb_ack_o for exactly one cycle, then go to HOLD.
REQ-015 HOLD: SHALL keep wb_ack_o low for one cycle, then return to IDLE. No back-to-back acks.
REQ-016 Hit latency SHALL be 1 cycle from request sample to ack. Miss latency SHALL be the fill duration plus 1 cycle.
REQ-017 Write request: SHALL go to RESP without a master access, write nothing, and clear valid.
REQ-018 wb_sel_i SHALL be ignored; reads always return the full word.
REQ-019 If wb_cyc_i drops during FILL, the fill SHALL complete and update the line, and no slave ack SHALL be issued.
REQ-020 inv_i in IDLE SHALL clear valid in the next cycle. inv_i and a hit in the same cycle SHALL be treated as a miss.
REQ-021 The counter SHALL wrap at 3 -> 0 within a line. The tag SHALL be compared only on bits [adr_width-1:4].

Reset
REQ-022 On sys_rst the block SHALL produce:
  - state IDLE, valid 0, counter 0;
  - wb_ack_o 0, wb_dat_o 0;
  - m_cyc_o 0, m_stb_o 0, m_adr_o 0, m_sel_o 4'b1111;
  - hit_count_o 0.
REQ-023 Reset mid-FILL SHALL drop m_cyc_o and m_stb_o in the next cycle and discard partial line data.

Configuration
REQ-024 With NORFLASH_LINEBUF_STATS_EN defined:
  - hit_count_o SHALL increment by 1 on every hit ack;
  - it wraps at 2^32.
REQ-025 Without NORFLASH_LINEBUF_STATS_EN:
  - hit_count_o SHALL be constant 0;
  - no counter register is generated.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, the line size (4 words) and the sel constant 4'b1111.
REQ-027 The tag/data line store SHALL be one sub-module, norflash_linebuf_store. The FSM stays in the top module.

Verification
REQ-028 Read 0x0000fff4 after reset, flash model returning adr+1:
  - 4 master reads occur at 0xfff0, 0xfff4, 0xfff8, 0xfffc;
  - the ack returns 0x0000fff5.
REQ-029 Read 0x0000fff8 after REQ-028: ack 1 cycle after the request, data 0x0000fff9, no master cycle, hit_count_o = 1 (macro on).
REQ-030 Read 0x00000010 after the line holds 0xfff0: miss, fill 0x10..0x1c, data 0x00000011.
REQ-031 inv_i pulse, then read 0x00000014: a refill occurs with 4 master reads. With inv_i during a fill, the next same-line read also refills.
REQ-032 Drop wb_cyc_i mid-fill: the fill completes with no wb_ack_o. The next read of the same line hits in 1 cycle.
REQ-033 Assert sys_rst mid-fill: m_cyc_o = 0 the next cycle, valid = 0, and the following read misses.
